// File: rtl/router_fifo.sv
// router_fifo: 16x9 packet-aware FIFO between the register stage and a destination port.
//   clock      in   rising-edge clock
//   resetn     in   synchronous active-low reset
//   soft_reset in   synchronous flush (read timeout from the router FSM)
//   write_enb  in   write request, data_in/lfd_state captured when not full
//   read_enb   in   read request, data_out updated next edge when not empty
//   lfd_state  in   data_in is a packet header
//   data_in    in   [7:0] byte to store
//   empty      out  no entries held
//   full       out  16 entries held
//   data_out   out  [7:0] registered read data
module router_fifo (
    input  logic       clock,
    input  logic       resetn,
    input  logic       soft_reset,
    input  logic       write_enb,
    input  logic       read_enb,
    input  logic       lfd_state,
    input  logic [7:0] data_in,
    output logic       empty,
    output logic       full,
    output logic [7:0] data_out
);
    logic [8:0] mem [16];
    logic [4:0] wr_q, wr_d, rd_q, rd_d;
    logic [6:0] cnt_q, cnt_d;
    logic [7:0] dout_q, dout_d;
    logic [8:0] rd_e;
    logic       do_wr, do_rd;
    assign empty    = wr_q == rd_q;
    assign full     = wr_q == {~rd_q[4], rd_q[3:0]};
    assign do_wr    = write_enb && !full;
    assign do_rd    = read_enb && !empty;
    assign rd_e     = mem[rd_q[3:0]];
    assign data_out = dout_q;
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (soft_reset) begin
            wr_d   = '0;
            rd_d   = '0;
            cnt_d  = '0;
            dout_d = 8'h00;
        end else begin
            if (do_wr) wr_d = wr_q + 5'd1;
            if (do_rd) begin
                rd_d   = rd_q + 5'd1;
                dout_d = rd_e[7:0];
                // header loads payload length plus one for the parity byte
                cnt_d  = rd_e[8] ? {1'b0, rd_e[7:2]} + 7'd1 : (cnt_q != '0 ? cnt_q - 7'd1 : cnt_q);
            end else if (cnt_q == '0) begin
                dout_d = 8'h00;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            dout_q <= 8'h00;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end
    // storage has no reset; entries are only read after being written
    always_ff @(posedge clock)
        if (resetn && !soft_reset && do_wr) mem[wr_q[3:0]] <= {lfd_state, data_in};
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: scoreboard bench for router_fifo.
module tb_router_fifo;
    logic       clock = 0;
    logic       resetn = 0;
    logic       soft_reset = 0;
    logic       write_enb = 0;
    logic       read_enb = 0;
    logic       lfd_state = 0;
    logic [7:0] data_in = 0;
    logic       empty, full;
    logic [7:0] data_out;

    router_fifo dut (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
        .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
        .data_in(data_in), .empty(empty), .full(full), .data_out(data_out)
    );

    always #5 clock = ~clock;

    logic [8:0] mdl [$];
    logic [7:0] exp_q [$];
    logic [6:0] m_cnt = 0;
    logic [7:0] m_dout = 0;
    int n_checks = 0;
    int n_fail = 0;

    // drive one cycle and advance the reference model using pre-edge full/empty
    task automatic step(input logic we, input logic re, input logic lfd, input logic [7:0] din, input logic sr);
        logic [8:0] e;
        bit mf, me;
        write_enb = we; read_enb = re; lfd_state = lfd; data_in = din; soft_reset = sr;
        mf = mdl.size() == 16;
        me = mdl.size() == 0;
        @(posedge clock); #1;
        if (sr) begin
            mdl.delete(); m_cnt = 0; m_dout = 0;
        end else begin
            if (re && !me) begin
                e = mdl.pop_front();
                m_dout = e[7:0];
                exp_q.push_back(e[7:0]);
                if (e[8]) m_cnt = 7'(e[7:2]) + 7'd1;
                else if (m_cnt != 0) m_cnt = m_cnt - 7'd1;
            end else if (m_cnt == 0) m_dout = 0;
            if (we && !mf) mdl.push_back({lfd, din});
        end
        write_enb = 0; read_enb = 0; lfd_state = 0; soft_reset = 0;
    endtask

    task automatic do_reset();
        resetn = 0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1;
        mdl.delete(); exp_q.delete(); m_cnt = 0; m_dout = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", data_out); end
    endtask

    task automatic test_packet();
        logic [7:0] pk [5] = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5F};
        logic [7:0] e;
        for (int i = 0; i < 5; i++) step(1, 0, i == 0, pk[i], 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0);
            e = exp_q.size() ? exp_q.pop_front() : 8'hXX;
            n_checks++; if (data_out !== e || data_out !== pk[i]) begin n_fail++; $display("FAIL packet_rd%0d got %h want %h", i, data_out, pk[i]); end
        end
        step(0, 0, 0, 0, 0);
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL packet_idle got %h want 00", data_out); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL packet_empty got %b want 1", empty); end
    endtask

    task automatic test_hold();
        step(1, 0, 1, 8'h0D, 0);
        step(1, 0, 0, 8'hA1, 0);
        step(0, 1, 0, 0, 0);
        void'(exp_q.pop_front());
        step(0, 0, 0, 0, 0);
        n_checks++; if (data_out !== 8'h0D) begin n_fail++; $display("FAIL hold_hdr got %h want 0D", data_out); end
        step(0, 1, 0, 0, 0);
        void'(exp_q.pop_front());
        step(0, 0, 0, 0, 0);
        n_checks++; if (data_out !== 8'hA1) begin n_fail++; $display("FAIL hold_pay got %h want A1", data_out); end
        step(0, 0, 0, 0, 1);
        n_checks++; if (data_out !== 8'h00 || empty !== 1'b1) begin n_fail++; $display("FAIL hold_flush got %h/%b want 00/1", data_out, empty); end
    endtask

    task automatic test_full();
        logic [7:0] e;
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 8'h20 + 8'(i), 0);
            if (i == 14) begin
                n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_at15 got %b want 0", full); end
            end
        end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_at16 got %b want 1", full); end
        step(1, 0, 0, 8'hFF, 0);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_drop got %b want 1", full); end
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 0, 0);
            e = exp_q.size() ? exp_q.pop_front() : 8'hXX;
            n_checks++; if (data_out !== e || data_out !== 8'h20 + 8'(i)) begin n_fail++; $display("FAIL full_rd%0d got %h want %h", i, data_out, 8'h20 + 8'(i)); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drained got %b want 1", empty); end
    endtask

    task automatic test_full_rw();
        logic [7:0] e;
        for (int i = 0; i < 16; i++) step(1, 0, 0, 8'h40 + 8'(i), 0);
        step(1, 1, 0, 8'hEE, 0);
        e = exp_q.size() ? exp_q.pop_front() : 8'hXX;
        n_checks++; if (data_out !== e || data_out !== 8'h40) begin n_fail++; $display("FAIL fullrw_rd got %h want 40", data_out); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL fullrw_full got %b want 0", full); end
        for (int i = 1; i < 16; i++) begin
            step(0, 1, 0, 0, 0);
            void'(exp_q.pop_front());
        end
        n_checks++; if (empty !== 1'b1 || data_out !== 8'h4F) begin n_fail++; $display("FAIL fullrw_drop got %b/%h want 1/4F", empty, data_out); end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_empty_rw();
        logic [7:0] e;
        step(1, 1, 0, 8'h11, 0);
        n_checks++; if (data_out !== m_dout || data_out !== 8'h00) begin n_fail++; $display("FAIL emptyrw_dout got %h want 00", data_out); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL emptyrw_empty got %b want 0", empty); end
        step(0, 1, 0, 0, 0);
        e = exp_q.size() ? exp_q.pop_front() : 8'hXX;
        n_checks++; if (data_out !== e || data_out !== 8'h11) begin n_fail++; $display("FAIL emptyrw_next got %h want 11", data_out); end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_soft_reset();
        step(1, 0, 1, 8'h0D, 0);
        step(1, 0, 0, 8'hA1, 0);
        step(1, 0, 0, 8'hA2, 0);
        step(0, 1, 0, 0, 0);
        void'(exp_q.pop_front());
        step(1, 1, 0, 8'h77, 1);
        n_checks++; if (empty !== 1'b1 || data_out !== 8'h00) begin n_fail++; $display("FAIL sr_flush got %b/%h want 1/00", empty, data_out); end
        step(0, 0, 0, 0, 0);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sr_wdrop got %b want 1", empty); end
        step(1, 0, 0, 8'h33, 0);
        step(0, 1, 0, 0, 0);
        void'(exp_q.pop_front());
        step(0, 0, 0, 0, 0);
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL sr_cnt got %h want 00", data_out); end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 1, 8'h09, 0);
        step(1, 0, 0, 8'hB1, 0);
        step(1, 0, 0, 8'hB2, 0);
        step(0, 1, 0, 0, 0);
        void'(exp_q.pop_front());
        write_enb = 1; data_in = 8'hB3;
        resetn = 0;
        @(posedge clock); #1;
        write_enb = 0;
        resetn = 1;
        mdl.delete(); exp_q.delete(); m_cnt = 0; m_dout = 0;
        n_checks++; if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin n_fail++; $display("FAIL rstmid got e%b f%b %h want e1 f0 00", empty, full, data_out); end
        step(1, 0, 0, 8'h44, 0);
        step(0, 1, 0, 0, 0);
        void'(exp_q.pop_front());
        n_checks++; if (data_out !== 8'h44) begin n_fail++; $display("FAIL rstmid_rd got %h want 44", data_out); end
        step(0, 0, 0, 0, 0);
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rstmid_cnt got %h want 00", data_out); end
    endtask

    task automatic test_truncated();
        logic [8:0] seq [6] = '{9'h10D, 9'h0A1, 9'h105, 9'h0B1, 9'h0B2, 9'h0B3};
        logic [7:0] e;
        for (int i = 0; i < 6; i++) step(1, 0, seq[i][8], seq[i][7:0], 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0, 0);
            e = exp_q.size() ? exp_q.pop_front() : 8'hXX;
            n_checks++; if (data_out !== e) begin n_fail++; $display("FAIL trunc_rd%0d got %h want %h", i, data_out, e); end
        end
        step(0, 0, 0, 0, 0);
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL trunc_idle got %h want 00", data_out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        for (int i = 0; i < 200; i++) begin
            step(i < 100 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 i < 100 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0),
                 $urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 99) == 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++; if (data_out !== e) begin n_fail++; $display("FAIL b2b_rd%0d got %h want %h", i, data_out, e); end
            end
            n_checks++; if (data_out !== m_dout) begin n_fail++; $display("FAIL b2b_dout%0d got %h want %h", i, data_out, m_dout); end
            n_checks++; if (empty !== (mdl.size() == 0) || full !== (mdl.size() == 16)) begin n_fail++; $display("FAIL b2b_flags%0d got e%b f%b want size %0d", i, empty, full, mdl.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_hold();
        test_full();
        test_full_rw();
        test_empty_rw();
        test_soft_reset();
        test_reset_mid();
        test_truncated();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 The block SHALL use reset resetn, synchronous, active-low, and clock clock.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: resetn  input  1  synchronous active-low reset.
REQ-004 Port: soft_reset  input  1  synchronous active-high flush; the router FSM asserts it on a read timeout.
REQ-005 Port: write_enb  input  1  write request from the register stage.
REQ-006 Port: read_enb  input  1  read request from the destination port.
REQ-007 Port: lfd_state  input  1  marks the data_in word as a packet header.
REQ-008 Port: data_in  input  8  byte from the register stage (its dout).
REQ-009 Port: empty  output  1  FIFO holds no entries.
REQ-010 Port: full  output  1  FIFO holds 16 entries.
REQ-011 Port: data_out  output  8  registered read data.

Function
REQ-012 Storage SHALL be 16 entries x 9 bits; bit 8 = header flag, bits 7:0 = byte.
REQ-013 Write and read pointers SHALL be 5 bits each; bits 3:0 address storage and bit 4 is the wrap bit; pointers wrap 31->0.
REQ-014 empty SHALL be combinational: 1 when the pointers are equal.
REQ-015 full SHALL be combinational: 1 when the pointers differ only in bit 4.
REQ-016 Write: when write_enb=1 and full=0, store {lfd_state,data_in} at the write pointer and increment it; when full=1, ignore the write with no state change.
REQ-017 Read: when read_enb=1 and empty=0, drive data_out with the stored byte on the next edge (1-cycle latency) and increment the read pointer; when empty=1, ignore the read.
REQ-018 Full/empty SHALL be evaluated from the pre-edge pointers: a write while full is dropped even if a read occurs in the same cycle, and a read while empty is dropped even if a write occurs in the same cycle.
REQ-019 A legal read and a legal write in the same cycle SHALL both complete; the occupancy is unchanged.
REQ-020 Packet counter (7 bits): on a read of an entry with bit 8=1, load byte[7:2]+1 (payload length plus the parity byte).
REQ-021 On a read of an entry with bit 8=0 while the counter is >0, decrement the counter by 1; it never underflows below 0.
REQ-022 When the counter is 0 and no legal read occurs in a cycle, data_out SHALL be driven to 8'h00 on that edge.
REQ-023 When the counter is >0 and no legal read occurs, data_out SHALL hold its value.
REQ-024 A header read while the counter is >0 (truncated packet) SHALL reload the counter from the new header.
REQ-025 Priority: resetn > soft_reset > read/write.
REQ-026 soft_reset SHALL set both pointers to 0, the counter to 0 and data_out to 8'h00, and SHALL drop any read or write in the same cycle.

Reset
REQ-027 With resetn=0 at an edge: pointers=0, counter=0, data_out=8'h00, empty=1, full=0.
REQ-028 Storage contents SHALL be unspecified after reset and are never observable before being written.

Verification
REQ-029 Write header 8'h0D (lfd=1), payload 8'hA1, 8'hA2, 8'hA3, then parity 8'h5F; read 5 times -> data_out = 0D, A1, A2, A3, 5F on successive cycles, each 1 cycle after its read; the counter ends at 0 and data_out=00 the next idle cycle.
REQ-030 16 writes with read_enb=0 -> full=1 after the 16th; a 17th write with byte 8'hFF is dropped; 16 reads return the original order, no FF, then empty=1.
REQ-031 At full, simultaneous write+read -> read returns the oldest entry, the write is dropped, and full=0 afterwards.
REQ-032 At empty, simultaneous write 8'h11 + read -> read is ignored and data_out is unchanged; the next read returns 8'h11.
REQ-033 Write 3 entries, pulse soft_reset together with write_enb=1 -> empty=1, data_out=00, and the write is dropped.
REQ-034 resetn=0 while a packet is in progress (counter=3) -> next cycle empty=1, full=0, data_out=00, counter=0.
